// File: rtl/rc_defs.sv
// rtl/rc_defs.sv - shared state encoding and default timing for the reconfiguration sequencer
package rc_defs;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_XFER = 3'd2;
  localparam logic [2:0] ST_HOLD = 3'd3;
  localparam logic [2:0] ST_REL  = 3'd4;

  localparam int RST_HOLD_DEF    = 4;
  localparam int ACK_TIMEOUT_DEF = 1024;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    REQ  = ST_REQ,
    XFER = ST_XFER,
    HOLD = ST_HOLD,
    REL  = ST_REL
  } rc_state_e;

endpackage

// File: rtl/rc_sequencer_if.sv
// rtl/rc_sequencer_if.sv - region handshake, transfer engine and status signals of the sequencer
interface rc_sequencer_if;

  logic rc_start;
  logic rc_reqn;
  logic rc_ackn;
  logic rc_rstn;
  logic rc_isolate;
  logic xfer_start;
  logic xfer_done;
  logic rc_busy;
  logic rc_done;
  logic rc_timeout;

  modport master (
    input  rc_start, rc_ackn, xfer_done,
    output rc_reqn, rc_rstn, rc_isolate, xfer_start, rc_busy, rc_done, rc_timeout
  );

  modport slave (
    output rc_start, rc_ackn, xfer_done,
    input  rc_reqn, rc_rstn, rc_isolate, xfer_start, rc_busy, rc_done, rc_timeout
  );

endinterface

// File: rtl/rc_sequencer_timer.sv
// rtl/rc_sequencer_timer.sv - clearable saturating up-counter flagging the LIMIT-th enabled edge
module rc_timer #(
  parameter int LIMIT = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic tc
);

  // LIMIT of 0 means the terminal count never fires
  localparam int W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W:0]   cnt_inc;

  // tc is high on the enabled edge that brings the count to LIMIT; count saturates
  always_comb begin
    cnt_inc = {1'b0, cnt_q} + (W+1)'(1);
    tc      = (LIMIT != 0) && en && (cnt_inc == (W+1)'(LIMIT));
    cnt_d   = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != W'(LIMIT))) begin
      cnt_d = cnt_inc[W-1:0];
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rc_sequencer.sv
// rtl/rc_sequencer.sv - static-side reconfiguration sequencer for one reconfigurable region
module rc_sequencer
  import rc_defs::*;
#(
  parameter int RST_HOLD    = RST_HOLD_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  rc_sequencer_if.master bus
);

  rc_state_e state_q, state_d;
  logic rc_reqn_q, rc_reqn_d;
  logic rc_rstn_q, rc_rstn_d;
  logic rc_isolate_q, rc_isolate_d;
  logic xfer_start_q, xfer_start_d;
  logic rc_busy_q, rc_busy_d;
  logic rc_done_q, rc_done_d;
  logic rc_timeout_q, rc_timeout_d;
  logic tmo_tc, hold_tc;

  rc_timer #(.LIMIT(ACK_TIMEOUT)) u_tmo_timer (
    .clk  (clk),
    .rstn (rstn),
    .clr  (state_q != REQ),
    .en   (state_q == REQ),
    .tc   (tmo_tc)
  );

  rc_timer #(.LIMIT(RST_HOLD)) u_hold_timer (
    .clk  (clk),
    .rstn (rstn),
    .clr  (state_q != HOLD),
    .en   (state_q == HOLD),
    .tc   (hold_tc)
  );

  // next state, event pulses, and region outputs decoded from the next state
  always_comb begin
    state_d      = state_q;
    xfer_start_d = 1'b0;
    rc_done_d    = 1'b0;
    rc_timeout_d = 1'b0;
    case (state_q)
      IDLE: if (bus.rc_start) state_d = REQ;
      REQ: begin
        if (!bus.rc_ackn) begin
          state_d      = XFER;
          xfer_start_d = 1'b1;
        end else if (tmo_tc) begin
          state_d      = IDLE;
          rc_timeout_d = 1'b1;
        end
      end
      // a done seen alongside xfer_start belongs to a previous transfer
      XFER: if (bus.xfer_done && !xfer_start_q) state_d = HOLD;
      HOLD: if (hold_tc) state_d = REL;
      REL: begin
        state_d   = IDLE;
        rc_done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    rc_reqn_d    = 1'b1;
    rc_rstn_d    = 1'b1;
    rc_isolate_d = 1'b0;
    rc_busy_d    = (state_d != IDLE);
    case (state_d)
      REQ:        rc_reqn_d = 1'b0;
      XFER, HOLD: begin
        rc_rstn_d    = 1'b0;
        rc_isolate_d = 1'b1;
      end
      REL:        rc_isolate_d = 1'b1;
      default:    ;
    endcase
  end

  // state and output registers; reset keeps the region isolated and in reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      rc_reqn_q    <= 1'b1;
      rc_rstn_q    <= 1'b0;
      rc_isolate_q <= 1'b1;
      xfer_start_q <= 1'b0;
      rc_busy_q    <= 1'b0;
      rc_done_q    <= 1'b0;
      rc_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rc_reqn_q    <= rc_reqn_d;
      rc_rstn_q    <= rc_rstn_d;
      rc_isolate_q <= rc_isolate_d;
      xfer_start_q <= xfer_start_d;
      rc_busy_q    <= rc_busy_d;
      rc_done_q    <= rc_done_d;
      rc_timeout_q <= rc_timeout_d;
    end
  end

  assign bus.rc_reqn    = rc_reqn_q;
  assign bus.rc_rstn    = rc_rstn_q;
  assign bus.rc_isolate = rc_isolate_q;
  assign bus.xfer_start = xfer_start_q;
  assign bus.rc_busy    = rc_busy_q;
  assign bus.rc_done    = rc_done_q;
  assign bus.rc_timeout = rc_timeout_q;

endmodule

// File: tb/tb_rc_sequencer.sv
// tb/tb_rc_sequencer.sv - directed self-checking bench for rc_sequencer
module tb_rc_sequencer;

  logic clk;
  logic rstn;
  int   vecs;
  int   errs;

  rc_sequencer_if bus();

  rc_sequencer #(.RST_HOLD(4), .ACK_TIMEOUT(16)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {reqn, rstn, isolate, xfer_start, busy, done, timeout}
  logic [6:0] obs;
  assign obs = {bus.rc_reqn, bus.rc_rstn, bus.rc_isolate, bus.xfer_start,
                bus.rc_busy, bus.rc_done, bus.rc_timeout};

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [6:0] exp;
    rstn = 1'b0;
    tick();
    tick();
    exp = 7'b1010000;
    vecs++;
    if (obs !== exp) begin
      $display("FAIL reset_values got %b want %b", obs, exp);
      errs++;
    end
    rstn = 1'b1;
    tick();
    exp = 7'b1100000;
    vecs++;
    if (obs !== exp) begin
      $display("FAIL reset_release got %b want %b", obs, exp);
      errs++;
    end
  endtask

  task automatic test_normal();
    logic [6:0] exp;
    int c;
    for (int cyc = 10; cyc <= 28; cyc++) begin
      bus.rc_start  = (cyc == 10);
      bus.rc_ackn   = !(cyc == 13);
      bus.xfer_done = (cyc == 20);
      tick();
      c = cyc + 1;
      exp = {!(c >= 11 && c <= 13), !(c >= 14 && c <= 24), (c >= 14 && c <= 25),
             (c == 14), (c >= 11 && c <= 25), (c == 26), 1'b0};
      vecs++;
      if (obs !== exp) begin
        $display("FAIL normal cyc %0d got %b want %b", c, obs, exp);
        errs++;
      end
    end
  endtask

  task automatic test_timeout();
    logic [6:0] exp;
    int c;
    for (int cyc = 0; cyc <= 19; cyc++) begin
      bus.rc_start  = (cyc == 0);
      bus.rc_ackn   = 1'b1;
      bus.xfer_done = 1'b0;
      tick();
      c = cyc + 1;
      exp = {!(c >= 1 && c <= 16), 1'b1, 1'b0, 1'b0, (c >= 1 && c <= 16), 1'b0, (c == 17)};
      vecs++;
      if (obs !== exp) begin
        $display("FAIL timeout cyc %0d got %b want %b", c, obs, exp);
        errs++;
      end
    end
  endtask

  task automatic test_ack_at_timeout();
    logic [6:0] exp;
    int c;
    for (int cyc = 0; cyc <= 26; cyc++) begin
      bus.rc_start  = (cyc == 0);
      bus.rc_ackn   = !(cyc == 16);
      bus.xfer_done = (cyc == 19);
      tick();
      c = cyc + 1;
      exp = {!(c >= 1 && c <= 16), !(c >= 17 && c <= 23), (c >= 17 && c <= 24),
             (c == 17), (c >= 1 && c <= 24), (c == 25), 1'b0};
      vecs++;
      if (obs !== exp) begin
        $display("FAIL ack_at_timeout cyc %0d got %b want %b", c, obs, exp);
        errs++;
      end
    end
  endtask

  task automatic test_ignored_inputs();
    logic [6:0] exp;
    int c;
    int dones;
    dones = 0;
    for (int cyc = 0; cyc <= 16; cyc++) begin
      bus.rc_start  = (cyc == 1) || (cyc == 9);
      bus.rc_ackn   = !((cyc == 0) || (cyc == 3) || (cyc == 14));
      bus.xfer_done = (cyc == 4) || (cyc == 7) || (cyc == 10);
      tick();
      c = cyc + 1;
      if (bus.rc_done === 1'b1) dones++;
      exp = {!(c == 2 || c == 3), !(c >= 4 && c <= 11), (c >= 4 && c <= 12),
             (c == 4), (c >= 2 && c <= 12), (c == 13), 1'b0};
      vecs++;
      if (obs !== exp) begin
        $display("FAIL ignored_inputs cyc %0d got %b want %b", c, obs, exp);
        errs++;
      end
    end
    vecs++;
    if (dones !== 1) begin
      $display("FAIL ignored_done_count got %0d want 1", dones);
      errs++;
    end
  endtask

  task automatic test_reset_in_xfer();
    logic [6:0] exp;
    int c;
    for (int cyc = 0; cyc <= 6; cyc++) begin
      bus.rc_start  = (cyc == 0);
      bus.rc_ackn   = !(cyc == 1);
      bus.xfer_done = 1'b0;
      rstn          = (cyc != 3);
      tick();
      c = cyc + 1;
      exp = {!(c == 1), !(c >= 2 && c <= 4), (c >= 2 && c <= 4),
             (c == 2), (c >= 1 && c <= 3), 1'b0, 1'b0};
      vecs++;
      if (obs !== exp) begin
        $display("FAIL reset_in_xfer cyc %0d got %b want %b", c, obs, exp);
        errs++;
      end
    end
    rstn = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp;
    int c;
    for (int cyc = 0; cyc <= 20; cyc++) begin
      bus.rc_start  = (cyc <= 17);
      bus.rc_ackn   = !((cyc == 1) || (cyc == 10));
      bus.xfer_done = (cyc == 3) || (cyc == 12);
      tick();
      c = cyc + 1;
      exp = {!(c == 1 || c == 10),
             !((c >= 2 && c <= 7) || (c >= 11 && c <= 16)),
             ((c >= 2 && c <= 8) || (c >= 11 && c <= 17)),
             (c == 2 || c == 11),
             ((c >= 1 && c <= 8) || (c >= 10 && c <= 17)),
             (c == 9 || c == 18),
             1'b0};
      vecs++;
      if (obs !== exp) begin
        $display("FAIL back_to_back cyc %0d got %b want %b", c, obs, exp);
        errs++;
      end
    end
    bus.rc_start = 1'b0;
  endtask

  initial begin
    vecs          = 0;
    errs          = 0;
    rstn          = 1'b0;
    bus.rc_start  = 1'b0;
    bus.rc_ackn   = 1'b1;
    bus.xfer_done = 1'b0;
    test_reset();
    test_normal();
    test_timeout();
    test_ack_at_timeout();
    test_ignored_inputs();
    test_reset_in_xfer();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
